// File: rtl/cic_pkg.sv
// Shared definitions for the CIC comb section: datapath width default,
// shift-control width, channel index type and the largest legal shift.
package cic_pkg;

  localparam int W_DEF     = 64;
  localparam int SHW       = 6;
  localparam int SHIFT_MAX = 63;

  // Channel index: 0 = ch0, 1 = ch1 (2-channel interleaved mode)
  typedef logic chan_t;

  typedef logic [SHW-1:0] shift_t;

endpackage

// File: rtl/comb_stage.sv
// One CIC comb differentiator: y = x - x_delayed, with a separate delay
// word per channel so two interleaved channels share one subtractor.
// The delay only advances on valid samples, so decimation gaps are ignored.
module comb_stage
  import cic_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x_i,
  input  logic         v_i,
  input  chan_t        ch_i,
  output logic [W-1:0] y_o,
  output logic         v_o,
  output chan_t        ch_o
);

  logic [W-1:0] dly_q [2];
  logic [W-1:0] y_q;
  logic         v_q;
  chan_t        ch_q;

  // Difference against the channel's previous sample; wraps modulo 2^W
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q[0] <= '0;
      dly_q[1] <= '0;
      y_q      <= '0;
      v_q      <= 1'b0;
      ch_q     <= 1'b0;
    end else begin
      y_q  <= x_i - dly_q[ch_i];
      v_q  <= v_i;
      ch_q <= ch_i;
      if (v_i) begin
        dly_q[ch_i] <= x_i;
      end
    end
  end

  assign y_o  = y_q;
  assign v_o  = v_q;
  assign ch_o = ch_q;

endmodule

// File: rtl/comb64_dec.sv
// Decimating CIC comb section following the 64-bit integrator chain.
// Decimates by (rate+1), runs STAGES comb differentiators per channel and
// slices the result at the selected shift into an OW-bit sample.
// Optional build macro ROUND_EN: round-half-up before slicing with
// positive saturation; undefined gives plain truncation.
module comb64_dec
  import cic_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int STAGES = 5,
  parameter int RW     = 16,
  parameter int OW     = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  d,
  input  logic          n,
  input  logic [RW-1:0] rate,
  input  shift_t        shift,
  output logic [OW-1:0] q,
  output chan_t         ch,
  output logic          v
);

  logic          p_q;
  logic [RW-1:0] cnt_q;
  logic [RW-1:0] cnt_d;
  logic          end_period_s;
  logic          capture_s;

  logic [W-1:0]  cap_x_q;
  logic          cap_v_q;
  chan_t         cap_ch_q;

  logic [W-1:0]  sx_s  [STAGES+1];
  logic          sv_s  [STAGES+1];
  chan_t         sch_s [STAGES+1];

  logic [W-1:0]         src_s;
  logic signed [W+OW-1:0] ext_s;
  logic [OW-1:0]        scale_d;
  logic [OW-1:0]        q_q;
  chan_t                ch_q;
  logic                 v_q;

  // A period is one clock with one channel, or the ch0/ch1 pair ending at p=1
  assign end_period_s = ~n | p_q;
  assign capture_s    = (cnt_q == {RW{1'b0}});

  // Decimation counter: count down per period, reload rate after reaching zero
  always_comb begin
    cnt_d = cnt_q;
    if (end_period_s) begin
      if (cnt_q == {RW{1'b0}}) begin
        cnt_d = rate;
      end else begin
        cnt_d = cnt_q - {{(RW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Phase/counter state and the capture register feeding the comb chain
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q      <= 1'b0;
      cnt_q    <= '0;
      cap_x_q  <= '0;
      cap_v_q  <= 1'b0;
      cap_ch_q <= 1'b0;
    end else begin
      p_q      <= ~p_q;
      cnt_q    <= cnt_d;
      cap_x_q  <= d;
      cap_v_q  <= capture_s;
      cap_ch_q <= n & p_q;
    end
  end

  assign sx_s[0]  = cap_x_q;
  assign sv_s[0]  = cap_v_q;
  assign sch_s[0] = cap_ch_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    comb_stage #(.W(W)) u_stage (
      .clk  (clk),
      .rst  (rst),
      .x_i  (sx_s[k]),
      .v_i  (sv_s[k]),
      .ch_i (sch_s[k]),
      .y_o  (sx_s[k+1]),
      .v_o  (sv_s[k+1]),
      .ch_o (sch_s[k+1])
    );
  end

`ifdef ROUND_EN
  logic [W-1:0] rnd_s;
  logic         sat_s;

  // Half-LSB rounding term; positive overflow of the add saturates
  always_comb begin
    rnd_s = '0;
    if (shift != 6'd0) begin
      rnd_s = {{(W-1){1'b0}}, 1'b1} << (shift - 6'd1);
    end else begin
      rnd_s = '0;
    end
    src_s = sx_s[STAGES] + rnd_s;
    sat_s = ~sx_s[STAGES][W-1] & src_s[W-1];
  end
`else
  assign src_s = sx_s[STAGES];
`endif

  // Sign-extend above bit W-1 so large shifts still slice a signed value
  always_comb begin
    ext_s   = signed'({{OW{src_s[W-1]}}, src_s});
    scale_d = OW'(ext_s >>> shift);
`ifdef ROUND_EN
    if (sat_s) begin
      scale_d = {1'b0, {(OW-1){1'b1}}};
    end else begin
      scale_d = OW'(ext_s >>> shift);
    end
`endif
  end

  // Output register: scaled sample with its valid strobe and channel tag
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= '0;
      ch_q <= 1'b0;
      v_q  <= 1'b0;
    end else begin
      q_q  <= scale_d;
      ch_q <= sch_s[STAGES];
      v_q  <= sv_s[STAGES];
    end
  end

  assign q  = q_q;
  assign ch = ch_q;
  assign v  = v_q;

endmodule

// File: tb/tb_comb64_dec.sv
// Directed bench for comb64_dec: one single-stage instance for the
// arithmetic/decimation cases and one default-depth instance for latency
// and reset behaviour. Inputs change #1 after the rising edge.
module tb_comb64_dec;

  logic        clk;
  logic        rst;
  logic [63:0] d;
  logic        n;
  logic [15:0] rate;
  logic [5:0]  shift;

  logic [23:0] q1, q5;
  logic        ch1, ch5;
  logic        v1, v5;

  int n_cmp;
  int n_bad;

  comb64_dec #(.STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .d(d), .n(n), .rate(rate), .shift(shift),
    .q(q1), .ch(ch1), .v(v1)
  );

  comb64_dec u_dut5 (
    .clk(clk), .rst(rst), .d(d), .n(n), .rate(rate), .shift(shift),
    .q(q5), .ch(ch5), .v(v5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] base;
    logic [63:0] d0;
    logic        ev;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    d     = 64'd0;
    n     = 1'b0;
    rate  = 16'd0;
    shift = 6'd0;

    // 1. Reset held with random data: outputs stay cleared
    for (int i = 0; i < 3; i++) begin
      d = {$urandom(), $urandom()};
      step();
      check_eq("t1_v1", {63'd0, v1}, 64'd0);
      check_eq("t1_q1", {40'd0, q1}, 64'd0);
      check_eq("t1_ch1", {63'd0, ch1}, 64'd0);
      check_eq("t1_v5", {63'd0, v5}, 64'd0);
      check_eq("t1_q5", {40'd0, q5}, 64'd0);
    end

    // 2. One channel, rate=3, ramp: strobe every 4th clock, q 0,4,4,...
    rst  = 1'b0;
    rate = 16'd3;
    for (int c = 0; c < 22; c++) begin
      d = 64'(c);
      step();
      ev = (c >= 2) && (((c - 2) % 4) == 0);
      check_eq("t2_v", {63'd0, v1}, {63'd0, ev});
      if (ev) begin
        check_eq("t2_q", {40'd0, q1}, (c == 2) ? 64'd0 : 64'd4);
        check_eq("t2_ch", {63'd0, ch1}, 64'd0);
      end
      if (c < 6) check_eq("t2_v5_quiet", {63'd0, v5}, 64'd0);
    end

    // 3. Two channels, rate=1: ch0 ramps per own slot, ch1 constant 100
    n    = 1'b1;
    rate = 16'd1;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      d = ((c % 2) == 0) ? 64'(c / 2) : 64'd100;
      step();
      ev = (c >= 2) && (((c % 4) == 2) || ((c % 4) == 3));
      check_eq("t3_v", {63'd0, v1}, {63'd0, ev});
      if (ev && ((c % 4) == 2)) begin
        check_eq("t3_ch0", {63'd0, ch1}, 64'd0);
        check_eq("t3_q_ch0", {40'd0, q1}, (c == 2) ? 64'd0 : 64'd2);
      end
      if (ev && ((c % 4) == 3)) begin
        check_eq("t3_ch1", {63'd0, ch1}, 64'd1);
        check_eq("t3_q_ch1", {40'd0, q1}, (c == 3) ? 64'd100 : 64'd0);
      end
    end

    // 4. No decimation across the 2^64 wrap: difference stays 3
    n    = 1'b0;
    rate = 16'd0;
    do_reset();
    base = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int c = 0; c < 10; c++) begin
      d = base + 64'(3 * c);
      step();
      check_eq("t4_v", {63'd0, v1}, {63'd0, (c >= 2)});
      if (c >= 2) begin
        check_eq("t4_q", {40'd0, q1}, (c == 2) ? 64'h00FF_FFFE : 64'd3);
      end
    end

    // 5. shift=8 with comb result 0x180: rounds to 2, truncates to 1
    shift = 6'd8;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      d = 64'(c * 384);
      step();
      if (c >= 2) begin
        check_eq("t5_v", {63'd0, v1}, 64'd1);
`ifdef ROUND_EN
        check_eq("t5_q", {40'd0, q1}, (c == 2) ? 64'd0 : 64'd2);
`else
        check_eq("t5_q", {40'd0, q1}, (c == 2) ? 64'd0 : 64'd1);
`endif
      end
    end

    // 6. Default depth: mid-run reset, then first output is raw d after STAGES+1
    shift = 6'd0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      d = 64'h1234_0000 + 64'(5 * c);
      step();
    end
    check_eq("t6_v5_running", {63'd0, v5}, 64'd1);
    rst = 1'b1;
    step();
    check_eq("t6_v5_after_rst", {63'd0, v5}, 64'd0);
    check_eq("t6_q5_after_rst", {40'd0, q5}, 64'd0);
    rst = 1'b0;
    d0  = 64'h0000_0000_00AB_CDEF;
    for (int c = 0; c < 8; c++) begin
      d = d0 + 64'(c);
      step();
      if (c < 6) check_eq("t6_v5_latency", {63'd0, v5}, 64'd0);
      if (c == 6) begin
        check_eq("t6_v5_first", {63'd0, v5}, 64'd1);
        check_eq("t6_q5_first", {40'd0, q5}, 64'h00AB_CDEF);
        check_eq("t6_ch5_first", {63'd0, ch5}, 64'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
